chip8_regfile_mp: RTL and testbench

- Parametrised V-register file for the CHIP-8 core: one general write port, a dedicated flag (VF) write port and two registered read ports.
- Contains a built-in bulk-transfer sequencer that carries out FX55 (store V0..Vx to memory) and FX65 (load V0..Vx from memory) over a req/ack memory handshake.
- Sits between the decode/execute FSM and the memory arbiter.

---
 rtl/chip8_pkg.sv | 20 ++
 rtl/chip8_regfile_mp_if.sv | 33 +++
 rtl/chip8_bulk_seq.sv | 114 +++++++++++
 rtl/chip8_regfile_mp.sv | 102 ++++++++++
 tb/tb_chip8_regfile_mp.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/chip8_pkg.sv
// Shared constants, encodings and state type for the CHIP-8 V-register file.
package chip8_pkg;

    localparam int DATA_W   = 8;
    localparam int NUM_REGS = 16;
    localparam int SEL_W    = $clog2(NUM_REGS);
    localparam int ADDR_W   = 12;
    localparam int FLAG_REG = NUM_REGS - 1;

    // Bulk transfer direction as seen on bulk_dir.
    localparam logic BULK_STORE = 1'b0;  // FX55: V0..Vx -> memory
    localparam logic BULK_LOAD  = 1'b1;  // FX65: memory -> V0..Vx

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DONE
    } bulk_state_e;

endpackage

// File: rtl/chip8_regfile_mp_if.sv
// Memory request/acknowledge bus between the register file's bulk
// sequencer (master) and the memory arbiter (slave).
interface chip8_regfile_mp_if #(
    parameter int ADDR_W = chip8_pkg::ADDR_W,
    parameter int DATA_W = chip8_pkg::DATA_W
);

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );

endinterface

// File: rtl/chip8_bulk_seq.sv
// FX55/FX65 bulk-transfer sequencer: walks V0..Vx one register per memory
// acknowledge, fetching store data from the register array and returning
// load data through a dedicated write port.
module chip8_bulk_seq #(
    parameter int DATA_W   = chip8_pkg::DATA_W,
    parameter int NUM_REGS = chip8_pkg::NUM_REGS,
    parameter int SEL_W    = $clog2(NUM_REGS),
    parameter int ADDR_W   = chip8_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              bulk_start,
    input  logic              bulk_dir,
    input  logic [SEL_W-1:0]  bulk_last,
    input  logic [ADDR_W-1:0] bulk_base,
    output logic              bulk_busy,
    output logic              bulk_done,

    chip8_regfile_mp_if.master mem,

    // Store-data fetch: index presented now, data is the write-first value.
    output logic [SEL_W-1:0]  fetch_sel,
    input  logic [DATA_W-1:0] fetch_data,

    // Load write-back into the register array.
    output logic              load_we,
    output logic [SEL_W-1:0]  load_sel,
    output logic [DATA_W-1:0] load_data
);

    import chip8_pkg::*;

    bulk_state_e       state;
    logic              dir_q;
    logic [SEL_W-1:0]  last_q;
    logic [SEL_W-1:0]  idx;
    logic [ADDR_W-1:0] base_q;

    // Fetch index is the register the next memory beat will carry: V0 when a
    // transfer is being launched, otherwise the one after the current index.
    always_comb begin
        fetch_sel = '0;
        load_we   = 1'b0;
        load_sel  = idx;
        load_data = mem.mem_rdata;
        if (state != IDLE) begin
            fetch_sel = idx + SEL_W'(1);
        end
        if (state == XFER && mem.mem_ack && dir_q == BULK_LOAD) begin
            load_we = 1'b1;
        end
    end

    // Sequencer FSM with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            dir_q         <= BULK_STORE;
            last_q        <= '0;
            idx           <= '0;
            base_q        <= '0;
            bulk_busy     <= 1'b0;
            bulk_done     <= 1'b0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bulk_start) begin
                        state         <= XFER;
                        dir_q         <= bulk_dir;
                        last_q        <= bulk_last;
                        base_q        <= bulk_base;
                        idx           <= '0;
                        bulk_busy     <= 1'b1;
                        mem.mem_req   <= 1'b1;
                        mem.mem_we    <= (bulk_dir == BULK_STORE);
                        mem.mem_addr  <= bulk_base;
                        mem.mem_wdata <= fetch_data;
                    end
                end

                XFER: begin
                    if (mem.mem_ack) begin
                        if (idx == last_q) begin
                            state       <= DONE;
                            bulk_done   <= 1'b1;
                            mem.mem_req <= 1'b0;
                            mem.mem_we  <= 1'b0;
                        end else begin
                            idx           <= fetch_sel;
                            mem.mem_addr  <= base_q + ADDR_W'(fetch_sel);
                            mem.mem_wdata <= fetch_data;
                        end
                    end
                end

                DONE: begin
                    state     <= IDLE;
                    bulk_done <= 1'b0;
                    bulk_busy <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/chip8_regfile_mp.sv
// CHIP-8 V-register file: general write port, VF flag write port, two
// registered read ports with write-first bypass, and the FX55/FX65 bulk
// sequencer on a req/ack memory bus.
module chip8_regfile_mp #(
    parameter int DATA_W   = chip8_pkg::DATA_W,
    parameter int NUM_REGS = chip8_pkg::NUM_REGS,
    parameter int SEL_W    = $clog2(NUM_REGS),
    parameter int ADDR_W   = chip8_pkg::ADDR_W,
    parameter int FLAG_REG = NUM_REGS - 1
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              we,
    input  logic [SEL_W-1:0]  wsel,
    input  logic [DATA_W-1:0] wdata,
    input  logic              flag_we,
    input  logic [DATA_W-1:0] flag_data,

    input  logic [SEL_W-1:0]  rsel1,
    input  logic [SEL_W-1:0]  rsel2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,

    input  logic              bulk_start,
    input  logic              bulk_dir,
    input  logic [SEL_W-1:0]  bulk_last,
    input  logic [ADDR_W-1:0] bulk_base,
    output logic              bulk_busy,
    output logic              bulk_done,

    chip8_regfile_mp_if.master mem
);

    import chip8_pkg::*;

    localparam logic [SEL_W-1:0] FLAG_SEL = SEL_W'(FLAG_REG);

    logic [DATA_W-1:0] regs      [NUM_REGS];
    logic [DATA_W-1:0] regs_next [NUM_REGS];

    logic [SEL_W-1:0]  fetch_sel;
    logic [DATA_W-1:0] fetch_data;
    logic              load_we;
    logic [SEL_W-1:0]  load_sel;
    logic [DATA_W-1:0] load_data;

    chip8_bulk_seq #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .SEL_W    (SEL_W),
        .ADDR_W   (ADDR_W)
    ) u_seq (
        .clk        (clk),
        .reset      (reset),
        .bulk_start (bulk_start),
        .bulk_dir   (bulk_dir),
        .bulk_last  (bulk_last),
        .bulk_base  (bulk_base),
        .bulk_busy  (bulk_busy),
        .bulk_done  (bulk_done),
        .mem        (mem),
        .fetch_sel  (fetch_sel),
        .fetch_data (fetch_data),
        .load_we    (load_we),
        .load_sel   (load_sel),
        .load_data  (load_data)
    );

    // Post-edge register image: flag port overrides the general port on VF;
    // both are locked out while the sequencer owns the array. Reads and the
    // store-data fetch index this image, which gives write-first bypass.
    always_comb begin
        regs_next = regs;
        if (!bulk_busy) begin
            if (we) begin
                regs_next[wsel] = wdata;
            end
            if (flag_we) begin
                regs_next[FLAG_SEL] = flag_data;
            end
        end
        if (load_we) begin
            regs_next[load_sel] = load_data;
        end
        fetch_data = regs_next[fetch_sel];
    end

    // Commit the register image and register both read ports.
    always_ff @(posedge clk) begin
        if (reset) begin
            regs   <= '{default: '0};
            rdata1 <= '0;
            rdata2 <= '0;
        end else begin
            regs   <= regs_next;
            rdata1 <= regs_next[rsel1];
            rdata2 <= regs_next[rsel2];
        end
    end

endmodule

// File: tb/tb_chip8_regfile_mp.sv
// Self-checking bench for chip8_regfile_mp: transaction-level reference
// model compared every cycle, directed scenarios with literal expectations,
// then randomized traffic against a randomly-stalling memory responder.
module tb_chip8_regfile_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic        we, flag_we;
    logic [3:0]  wsel;
    logic [7:0]  wdata, flag_data;
    logic [3:0]  rsel1, rsel2;
    logic [7:0]  rdata1, rdata2;
    logic        bulk_start, bulk_dir;
    logic [3:0]  bulk_last;
    logic [11:0] bulk_base;
    logic        bulk_busy, bulk_done;

    chip8_regfile_mp_if #(.ADDR_W(12), .DATA_W(8)) mem_bus ();

    chip8_regfile_mp #(
        .DATA_W   (8),
        .NUM_REGS (16),
        .ADDR_W   (12)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .wsel       (wsel),
        .wdata      (wdata),
        .flag_we    (flag_we),
        .flag_data  (flag_data),
        .rsel1      (rsel1),
        .rsel2      (rsel2),
        .rdata1     (rdata1),
        .rdata2     (rdata2),
        .bulk_start (bulk_start),
        .bulk_dir   (bulk_dir),
        .bulk_last  (bulk_last),
        .bulk_base  (bulk_base),
        .bulk_busy  (bulk_busy),
        .bulk_done  (bulk_done),
        .mem        (mem_bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory responder ----------------
    logic [7:0] mem_arr [4096];
    int         wait_q [$];
    int         cur_wait = -1;
    int         wait_cnt = 0;
    bit         spur_en  = 1'b0;
    int         ack_cnt  = 0;
    int         done_cnt = 0;

    initial begin
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            mem_bus.mem_ack = 1'b0;
            if (reset) begin
                wait_cnt = 0;
                cur_wait = -1;
            end else if (mem_bus.mem_req) begin
                if (cur_wait < 0) cur_wait = (wait_q.size() != 0) ? wait_q.pop_front() : int'($urandom_range(0, 2));
                if (wait_cnt >= cur_wait) begin
                    mem_bus.mem_ack   = 1'b1;
                    mem_bus.mem_rdata = mem_arr[mem_bus.mem_addr];
                    wait_cnt = 0;
                    cur_wait = -1;
                end else begin
                    wait_cnt++;
                end
            end else if (spur_en && $urandom_range(0, 3) == 0) begin
                mem_bus.mem_ack   = 1'b1;
                mem_bus.mem_rdata = 8'($urandom);
            end
        end
    end

    always @(posedge clk) begin
        if (!reset && mem_bus.mem_req && mem_bus.mem_ack) begin
            ack_cnt++;
            if (mem_bus.mem_we) mem_arr[mem_bus.mem_addr] = mem_bus.mem_wdata;
        end
        if (bulk_done) done_cnt++;
    end

    // ---------------- reference model ----------------
    logic [7:0]  m_regs [16];
    logic [7:0]  m_rd1, m_rd2;
    bit          m_valid = 1'b0;
    bit          m_rst, m_active, m_done, m_busy, m_dir;
    int          m_k, m_last;
    logic [11:0] m_base;

    always @(posedge clk) begin
        logic [7:0] nx [16];
        bit         was_busy;
        if (reset) begin
            m_regs   = '{default: 8'h00};
            m_rd1    = 8'h00;
            m_rd2    = 8'h00;
            m_rst    = 1'b1;
            m_active = 1'b0;
            m_done   = 1'b0;
            m_busy   = 1'b0;
            m_valid  = 1'b1;
        end else begin
            m_rst    = 1'b0;
            was_busy = m_busy;
            nx       = m_regs;
            if (!was_busy) begin
                if (we)      nx[wsel] = wdata;
                if (flag_we) nx[15]   = flag_data;
            end
            if (m_done) begin
                m_done = 1'b0;
                m_busy = 1'b0;
            end else if (m_active) begin
                if (mem_bus.mem_ack) begin
                    if (m_dir) nx[m_k] = mem_bus.mem_rdata;
                    if (m_k == m_last) begin
                        m_active = 1'b0;
                        m_done   = 1'b1;
                    end else begin
                        m_k++;
                    end
                end
            end else if (bulk_start) begin
                m_active = 1'b1;
                m_busy   = 1'b1;
                m_dir    = bulk_dir;
                m_last   = int'(bulk_last);
                m_base   = bulk_base;
                m_k      = 0;
            end
            m_regs = nx;
            m_rd1  = nx[rsel1];
            m_rd2  = nx[rsel2];
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("rdata1", rdata1, m_rd1);
            chk("rdata2", rdata2, m_rd2);
            chk("bulk_busy", bulk_busy, m_busy);
            chk("bulk_done", bulk_done, m_done);
            chk("mem_req", mem_bus.mem_req, m_active);
            if (m_active) begin
                chk("mem_addr", mem_bus.mem_addr, 12'(m_base + 12'(m_k)));
                chk("mem_we", mem_bus.mem_we, !m_dir);
                chk("mem_wdata", mem_bus.mem_wdata, m_regs[m_k]);
            end
            if (m_rst) begin
                chk("rst_mem_we", mem_bus.mem_we, 0);
                chk("rst_mem_addr", mem_bus.mem_addr, 0);
                chk("rst_mem_wdata", mem_bus.mem_wdata, 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (bulk_busy && n < budget) begin
            step();
            n++;
        end
        chk(name, bulk_busy, 0);
    endtask

    task automatic start_bulk(input logic dir, input logic [3:0] last, input logic [11:0] base);
        bulk_start = 1'b1;
        bulk_dir   = dir;
        bulk_last  = last;
        bulk_base  = base;
        step();
        bulk_start = 1'b0;
    endtask

    initial begin
        int a0, d0, n;
        for (int i = 0; i < 4096; i++) mem_arr[i] = 8'($urandom);
        for (int i = 0; i < 16; i++) mem_arr[12'h300 + i] = 8'(8'hC0 + i);

        reset = 1'b1; we = 1'b0; flag_we = 1'b0; wsel = '0; wdata = '0; flag_data = '0;
        rsel1 = '0; rsel2 = '0; bulk_start = 1'b0; bulk_dir = 1'b0; bulk_last = '0; bulk_base = '0;
        repeat (3) step();
        reset = 1'b0;

        // Reset clears a written register; outputs idle while reset is held.
        we = 1'b1; wsel = 4'd3; wdata = 8'h5A;
        step();
        we = 1'b0; reset = 1'b1; rsel1 = 4'd3;
        step();
        chk("reset_rdata1", rdata1, 8'h00);
        chk("reset_busy", bulk_busy, 0);
        chk("reset_req", mem_bus.mem_req, 0);
        reset = 1'b0;

        // Write-first bypass.
        we = 1'b1; wsel = 4'd1; wdata = 8'h11;
        step();
        wsel = 4'd2; wdata = 8'hA7; rsel1 = 4'd2; rsel2 = 4'd1;
        step();
        we = 1'b0;
        chk("bypass_rdata1", rdata1, 8'hA7);
        chk("bypass_rdata2", rdata2, 8'h11);

        // Flag port beats general port on VF.
        we = 1'b1; wsel = 4'd15; wdata = 8'h33; flag_we = 1'b1; flag_data = 8'h01;
        step();
        we = 1'b0; flag_we = 1'b0; rsel1 = 4'd15;
        step();
        chk("flag_prio", rdata1, 8'h01);

        // FX55 across the address wrap with 0/2/1 wait states.
        for (int i = 0; i < 3; i++) begin
            we = 1'b1; wsel = 4'(i); wdata = 8'((i + 1) * 16);
            step();
        end
        we = 1'b0;
        wait_q.push_back(0); wait_q.push_back(2); wait_q.push_back(1);
        d0 = done_cnt;
        start_bulk(1'b0, 4'd2, 12'hFFE);
        we = 1'b1; wsel = 4'd0; wdata = 8'hFF;
        wait_idle(100, "store_timeout");
        we = 1'b0;
        chk("store_done_pulses", done_cnt - d0, 1);
        chk("store_mem_ffe", mem_arr[12'hFFE], 8'h10);
        chk("store_mem_fff", mem_arr[12'hFFF], 8'h20);
        chk("store_mem_000", mem_arr[12'h000], 8'h30);
        rsel1 = 4'd0;
        step();
        step();
        chk("store_we_blocked", rdata1, 8'h10);

        // FX65 of all sixteen registers.
        a0 = ack_cnt;
        start_bulk(1'b1, 4'd15, 12'h300);
        wait_idle(200, "load_timeout");
        chk("load_acks", ack_cnt - a0, 16);
        for (int i = 0; i < 16; i++) begin
            rsel1 = 4'(i);
            step();
            chk("load_reg", rdata1, 8'(8'hC0 + i));
        end

        // Reset after two load acks aborts without a done pulse.
        a0 = ack_cnt;
        d0 = done_cnt;
        start_bulk(1'b1, 4'd15, 12'h300);
        n = 0;
        while (ack_cnt - a0 < 2 && n < 50) begin
            step();
            n++;
        end
        chk("abort_acks_seen", (ack_cnt - a0 >= 2), 1);
        reset = 1'b1;
        step();
        chk("abort_req", mem_bus.mem_req, 0);
        chk("abort_busy", bulk_busy, 0);
        reset = 1'b0;
        rsel1 = 4'd0; rsel2 = 4'd1;
        step();
        step();
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_v0", rdata1, 8'h00);
        chk("abort_v1", rdata2, 8'h00);

        // Randomized traffic, spurious acks and occasional resets.
        spur_en = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            we         = ($urandom_range(0, 2) == 0);
            wsel       = 4'($urandom);
            wdata      = 8'($urandom);
            flag_we    = ($urandom_range(0, 4) == 0);
            flag_data  = 8'($urandom);
            rsel1      = 4'($urandom);
            rsel2      = 4'($urandom);
            bulk_start = ($urandom_range(0, 19) == 0);
            bulk_dir   = 1'($urandom);
            bulk_last  = 4'($urandom);
            bulk_base  = 12'($urandom);
            reset      = ($urandom_range(0, 599) == 0);
            step();
        end
        we = 1'b0; flag_we = 1'b0; bulk_start = 1'b0; reset = 1'b0;
        wait_idle(200, "final_timeout");
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
